// File: rtl/tod_pkg.sv
// Shared time-of-day constants and field helpers for the clock/calendar stages.
package tod_pkg;
  localparam int TIME_W = 7;

  typedef logic [TIME_W-1:0] tval_t;

  localparam tval_t SEC_MAX  = 7'd59;
  localparam tval_t MIN_MAX  = 7'd59;
  localparam tval_t HOUR_MAX = 7'd23;

  // Button slots, in the order the release detectors are instantiated
  localparam int BTN_IH = 0;
  localparam int BTN_DH = 1;
  localparam int BTN_IM = 2;
  localparam int BTN_DM = 3;
  localparam int BTN_ZS = 4;
  localparam int NUM_BTN = 5;

  typedef struct packed {
    tval_t hour;
    tval_t minute;
    tval_t second;
  } tod_t;

  function automatic tval_t wrap_inc(tval_t v, tval_t max);
    return (v >= max) ? '0 : v + 1'b1;
  endfunction

  function automatic tval_t wrap_dec(tval_t v, tval_t max);
    return (v == '0) ? max : v - 1'b1;
  endfunction
endpackage

// File: rtl/time_of_day_if.sv
// Control and display bundle between the time-of-day stage and its user/consumer side.
interface time_of_day_if;
  import tod_pkg::*;

  logic  run;
  logic  i_h, d_h, i_m, d_m, z_s;
  tval_t hour, minute, second;
  logic  sec_tick, day_tick;

  modport slave (
    input  run, i_h, d_h, i_m, d_m, z_s,
    output hour, minute, second, sec_tick, day_tick
  );

  modport master (
    output run, i_h, d_h, i_m, d_m, z_s,
    input  hour, minute, second, sec_tick, day_tick
  );
endinterface

// File: rtl/btn_release.sv
// Press-and-release detector: one pulse on the first low cycle after a press.
module btn_release (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic pulse
);
  logic flag_q, flag_d;

  always_comb begin
    flag_d = lvl;
    pulse  = flag_q & ~lvl;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flag_q <= 1'b0;
    else      flag_q <= flag_d;
  end
endmodule

// File: rtl/time_of_day.sv
// Prescaled hh:mm:ss clock with release-triggered adjust buttons and a midnight tick.
module time_of_day
  import tod_pkg::*;
#(
  parameter int CLK_HZ = 1000,
  parameter int PRE_W  = 10
) (
  input  logic          clk,
  input  logic          rst,
  time_of_day_if.slave  bus
);
  if (CLK_HZ < 2 || (2.0 ** PRE_W) < CLK_HZ) begin : g_bad_param
    $error("time_of_day: CLK_HZ must be >= 2 and fit in PRE_W bits");
  end

  logic [NUM_BTN-1:0] btn_lvl, rel;
  assign btn_lvl = {bus.z_s, bus.d_m, bus.i_m, bus.d_h, bus.i_h};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_release u_btn (.clk(clk), .rst(rst), .lvl(btn_lvl[b]), .pulse(rel[b]));
  end

  logic [PRE_W-1:0] pre_q, pre_d;
  tod_t             tod_q, tod_d;
  logic             sec_tick_q, sec_tick_d;
  logic             day_tick_q, day_tick_d;
  logic             sec_event;

  assign sec_event = bus.run && (pre_q == PRE_W'(CLK_HZ - 1));

  always_comb begin
    pre_d      = pre_q;
    tod_d      = tod_q;
    sec_tick_d = sec_event;
    day_tick_d = 1'b0;

    if (bus.run) pre_d = sec_event ? '0 : pre_q + 1'b1;

    // Natural advance first; a zero-seconds release swallows this second's carry
    if (sec_event && !rel[BTN_ZS]) begin
      tod_d.second = wrap_inc(tod_q.second, SEC_MAX);
      if (tod_q.second == SEC_MAX) begin
        tod_d.minute = wrap_inc(tod_q.minute, MIN_MAX);
        if (tod_q.minute == MIN_MAX) begin
          tod_d.hour = wrap_inc(tod_q.hour, HOUR_MAX);
          if (tod_q.hour == HOUR_MAX) day_tick_d = 1'b1;
        end
      end
    end

    // Adjustments land on the already-advanced fields; opposing releases cancel
    if (rel[BTN_IH] && !rel[BTN_DH])      tod_d.hour = wrap_inc(tod_d.hour, HOUR_MAX);
    else if (rel[BTN_DH] && !rel[BTN_IH]) tod_d.hour = wrap_dec(tod_d.hour, HOUR_MAX);

    if (rel[BTN_IM] && !rel[BTN_DM])      tod_d.minute = wrap_inc(tod_d.minute, MIN_MAX);
    else if (rel[BTN_DM] && !rel[BTN_IM]) tod_d.minute = wrap_dec(tod_d.minute, MIN_MAX);

    if (rel[BTN_ZS]) begin
      tod_d.second = '0;
      pre_d        = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q      <= '0;
      tod_q      <= '0;
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      tod_q      <= tod_d;
      sec_tick_q <= sec_tick_d;
      day_tick_q <= day_tick_d;
    end
  end

  assign bus.hour     = tod_q.hour;
  assign bus.minute   = tod_q.minute;
  assign bus.second   = tod_q.second;
  assign bus.sec_tick = sec_tick_q;
  assign bus.day_tick = day_tick_q;
endmodule

// File: tb/tb_time_of_day.sv
// Scoreboard bench for time_of_day at CLK_HZ=4: directed scenarios plus random button traffic.
module tb_time_of_day;
  localparam int HZ = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  time_of_day_if bus();

  time_of_day #(.CLK_HZ(HZ), .PRE_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { int h; int m; int s; int st; int dt; } exp_t;
  exp_t sbq[$];

  int n_chk = 0, n_err = 0, st_cnt = 0, dt_cnt = 0;
  int m_h = 0, m_m = 0, m_s = 0, m_pre = 0;
  bit [4:0] m_flag = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Compare one expected snapshot per clock edge, just after the edge
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (rst && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("hour",     bus.hour,     e.h);
      chk("minute",   bus.minute,   e.m);
      chk("second",   bus.second,   e.s);
      chk("sec_tick", bus.sec_tick, e.st);
      chk("day_tick", bus.day_tick, e.dt);
    end
    if (bus.sec_tick) st_cnt++;
    if (bus.day_tick) dt_cnt++;
  end

  // Drive one cycle of inputs (bits: i_h,d_h,i_m,d_m,z_s) and queue the expected result
  task automatic tick(input bit run, input bit [4:0] b);
    bit [4:0] rel;
    bit ev;
    int st, dt;
    bus.run = run;
    bus.i_h = b[0]; bus.d_h = b[1]; bus.i_m = b[2]; bus.d_m = b[3]; bus.z_s = b[4];
    rel = m_flag & ~b;
    m_flag = b;
    ev = run && (m_pre == HZ - 1);
    st = ev ? 1 : 0;
    dt = 0;
    if (run) m_pre = ev ? 0 : m_pre + 1;
    if (ev && !rel[4]) begin
      m_s++;
      if (m_s == 60) begin
        m_s = 0; m_m++;
        if (m_m == 60) begin
          m_m = 0; m_h++;
          if (m_h == 24) begin m_h = 0; dt = 1; end
        end
      end
    end
    if (rel[0] && !rel[1]) m_h = (m_h + 1) % 24;
    else if (rel[1] && !rel[0]) m_h = (m_h + 23) % 24;
    if (rel[2] && !rel[3]) m_m = (m_m + 1) % 60;
    else if (rel[3] && !rel[2]) m_m = (m_m + 59) % 60;
    if (rel[4]) begin m_s = 0; m_pre = 0; end
    sbq.push_back('{m_h, m_m, m_s, st, dt});
    @(negedge clk);
  endtask

  task automatic press(input int k, input bit run);
    tick(run, 5'(1 << k));
    tick(run, 5'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hour"},     bus.hour,     0);
    chk({tag, "_minute"},   bus.minute,   0);
    chk({tag, "_second"},   bus.second,   0);
    chk({tag, "_sec_tick"}, bus.sec_tick, 0);
    chk({tag, "_day_tick"}, bus.day_tick, 0);
  endtask

  // Called at a negedge: reset lands mid-cycle, outputs must clear without a clock
  task automatic do_reset();
    #2 rst = 1'b0;
    #1 chk_zero("rst_async");
    m_h = 0; m_m = 0; m_s = 0; m_pre = 0; m_flag = '0;
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int st0, dt0, s0, n;
    bit [4:0] rb;
    bus.run = 1'b0;
    bus.i_h = 1'b0; bus.d_h = 1'b0; bus.i_m = 1'b0; bus.d_m = 1'b0; bus.z_s = 1'b0;
    #1 chk_zero("rst_init");
    @(negedge clk);
    rst = 1'b1;

    // Free run: two seconds in eight cycles
    repeat (8) tick(1'b1, 5'b0);
    chk("run8_second", bus.second, 2);
    chk("run8_st_cnt", st_cnt, 2);
    chk("run8_dt_cnt", dt_cnt, 0);

    // Preset 23:59:xx, run to :59, then midnight rollover
    repeat (23) press(0, 1'b1);
    press(3, 1'b1);
    chk("preset_hour", bus.hour, 23);
    chk("preset_minute", bus.minute, 59);
    for (int i = 0; i < 400 && !(m_s == 59 && m_pre == 0); i++) tick(1'b1, 5'b0);
    chk("preset_second", bus.second, 59);
    dt0 = dt_cnt;
    repeat (4) tick(1'b1, 5'b0);
    chk("midnight_hour", bus.hour, 0);
    chk("midnight_minute", bus.minute, 0);
    chk("midnight_second", bus.second, 0);
    chk("midnight_day_tick", bus.day_tick, 1);
    chk("midnight_sec_tick", bus.sec_tick, 1);
    tick(1'b1, 5'b0);
    chk("midnight_dt_once", dt_cnt - dt0, 1);

    // Long hold of i_m at minute 59: single wrap on release, hour untouched
    press(3, 1'b1);
    repeat (10) tick(1'b1, 5'b00100);
    chk("hold_no_repeat", bus.minute, 59);
    tick(1'b1, 5'b0);
    chk("hold_release_min", bus.minute, 0);
    chk("hold_release_hour", bus.hour, 0);

    // Opposing hour releases cancel; d_h at 0 wraps to 23 without day_tick
    dt0 = dt_cnt;
    tick(1'b1, 5'b00011);
    tick(1'b1, 5'b0);
    chk("cancel_hour", bus.hour, 0);
    press(1, 1'b1);
    chk("dec_wrap_hour", bus.hour, 23);
    chk("dec_wrap_dt", dt_cnt - dt0, 0);

    // Frozen time, zero seconds, then full-second latency to the next tick
    s0 = m_s;
    st0 = st_cnt;
    repeat (20) tick(1'b0, 5'b0);
    chk("frozen_st", st_cnt - st0, 0);
    chk("frozen_second", bus.second, s0);
    press(4, 1'b0);
    chk("zs_second", bus.second, 0);
    n = 0;
    do begin
      tick(1'b1, 5'b0);
      n++;
    end while (!bus.sec_tick && n < 12);
    chk("zs_first_tick_lat", n, 4);

    // Reset mid-press and mid-second; the press must not survive reset
    repeat (2) tick(1'b1, 5'b0);
    tick(1'b1, 5'b00100);
    tick(1'b1, 5'b00100);
    do_reset();
    tick(1'b1, 5'b0);
    tick(1'b1, 5'b0);
    chk("post_rst_minute", bus.minute, 0);

    // Random traffic exercises simultaneous advance/adjust corners
    for (int i = 0; i < 600; i++) begin
      rb = 5'($urandom & $urandom & $urandom);
      tick(($urandom_range(0, 9) != 0), rb);
    end
    tick(1'b1, 5'b0);
    @(negedge clk);
    chk("sbq_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/time_of_day.md
Name: time_of_day

Overview:
- Upstream neighbour of the calendar (date) stage.
- Keeps hours/minutes/seconds from the fast system clock through a prescaler.
- Emits a one-cycle day_tick at the natural 23:59:59 -> 00:00:00 rollover; the calendar stage consumes day_tick as its day-advance input.
- Supports user adjustment through press-and-release buttons, in the same style as the calendar's set buttons.

Parameters:
- CLK_HZ, 1000: system clock cycles per second. Must be >= 2.
- PRE_W, 10: prescaler width. Must satisfy 2^PRE_W >= CLK_HZ.

Ports:
- clk  in  1  system clock (CLK_HZ); the only clock
- rst  in  1  asynchronous, active-low reset
- run  in  1  1 = time advances; 0 = prescaler and time frozen (adjust buttons still work)
- i_h  in  1  hour-up button, level, high while pressed
- d_h  in  1  hour-down button
- i_m  in  1  minute-up button
- d_m  in  1  minute-down button
- z_s  in  1  zero-seconds button
- hour  out  7  0..23, binary
- minute  out  7  0..59
- second  out  7  0..59
- sec_tick  out  1  one-cycle pulse when second advances
- day_tick  out  1  one-cycle pulse on natural midnight rollover

Behaviour:
- Reset (rst low, asynchronous): hour=0, minute=0, second=0, prescaler=0, sec_tick=0, day_tick=0, all button flags=0. Effective immediately, including mid-press and mid-second.
- Prescaler:
  - With run=1, counts 0..CLK_HZ-1 and wraps to 0.
  - sec_event = run && (prescaler == CLK_HZ-1), evaluated combinationally in that cycle.
  - With run=0, prescaler holds its value.
- Time advance, registered on the clock edge that ends a sec_event cycle:
  - second+1; 59 wraps to 0 and carries to minute.
  - minute 59 wraps to 0 and carries to hour.
  - hour 23 wraps to 0 and marks rollover.
- sec_tick: registered; high exactly the one cycle after the sec_event edge.
- day_tick: registered; high exactly the one cycle after the rollover edge. Never asserted by any button action.
- Buttons (per input, independent):
  - A flag is set while the input is high.
  - The action fires on the first cycle the input is low with the flag set; the flag clears the same cycle.
  - Result: exactly one action per press, latency 1 cycle after release. Holding a button does not repeat.
- Button actions (modular, no carry or borrow into other fields):
  - i_h: hour 23 -> 0, else +1.
  - d_h: hour 0 -> 23, else -1.
  - i_m: minute 59 -> 0, else +1.
  - d_m: minute 0 -> 59, else -1.
  - z_s: second=0 and prescaler=0, so the next sec_tick comes a full CLK_HZ cycles later.
- Simultaneous events in one cycle:
  - The natural advance (including its carries) is computed first; button actions are then applied to the advanced values.
  - i_h and d_h releasing together cancel (net 0); same for i_m and d_m.
  - z_s with a sec_event: second=0, prescaler=0, and no carry is propagated from that second.
  - A natural rollover with a simultaneous i_h release: day_tick still fires, hour=1.
- Outputs are held registers; no combinational path from inputs to outputs.

Decomposition:
- Shared package tod_pkg:
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, TIME_W=7
  - wrap-increment/decrement helper functions, reused by other time-domain stages
- Sub-module btn_release: one flag register, output pulse on the falling edge of the level input, async active-low reset. Instantiated 5 times (i_h, d_h, i_m, d_m, z_s).

Test Plan (CLK_HZ=4 in simulation):
- Reset, run=1, 8 cycles -> second=2; sec_tick pulses at cycles 4 and 8 (each 1 cycle wide); hour=minute=0, day_tick never high.
- Preset 23:59:59 via buttons (i_h released 23x, d_m once, d_s not needed: run until second=59), then 4 cycles -> 00:00:00; day_tick high exactly 1 cycle, concurrent with sec_tick.
- Hold i_m high 10 cycles, then release -> minute +1 exactly once, 1 cycle after release; no change to hour even at 59 -> 0.
- Release i_h and d_h in the same cycle -> hour unchanged; release d_h at hour 0 -> 23, day_tick stays 0.
- run=0 for 20 cycles -> prescaler/second frozen, no sec_tick; z_s release while frozen -> second=0; run=1 -> first sec_tick exactly 4 cycles later.
- Assert rst low mid-press of i_m and mid-second -> all outputs 0 immediately; release button after reset deasserts -> no minute action (flag cleared).
